// File: rtl/clk_div_ratio_ctrl.sv
// Ratio-change sequencer for the programmable clock divider:
// gates the divider enable at a divided-clock low phase, loads, resumes.
module clk_div_ratio_ctrl #(
  parameter int RATIO_W        = 8,
  parameter int INIT_RATIO     = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_req_valid,
  input  logic [RATIO_W-1:0] i_req_ratio,
  output logic               o_req_ready,
  input  logic               i_div_clk,
  output logic               o_clk_en,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout
);

  localparam int WW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] W_STEP = WW'(1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] S_STEP = SW'(1);

  localparam logic [RATIO_W-1:0] R_INIT = RATIO_W'(INIT_RATIO);
  localparam logic [RATIO_W-1:0] R_ONE  = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] R_TWO  = RATIO_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOW,
    S_GATE,
    S_LOAD,
    S_RESUME
  } state_t;

  state_t             state_q, state_d;
  logic [RATIO_W-1:0] pend_q, pend_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [SW-1:0]      scnt_q, scnt_d;
  logic               clk_en_q, clk_en_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               div_q, div_d;

  logic [RATIO_W-1:0] req_ratio;
  logic               fall;

  assign req_ratio = (i_req_ratio == '0) ? R_ONE : i_req_ratio;
  assign fall      = div_q & ~i_div_clk;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ratio_d   = ratio_q;
    wcnt_d    = wcnt_q;
    scnt_d    = scnt_q;
    clk_en_d  = clk_en_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    div_d     = i_div_clk;

    unique case (state_q)
      S_IDLE: begin
        clk_en_d = i_en;
        if (i_req_valid) begin
          pend_d    = req_ratio;
          timeout_d = 1'b0;
          wcnt_d    = '0;
          scnt_d    = '0;
          if (req_ratio == ratio_q) begin
            state_d = S_RESUME;
          end else if (!i_en || ratio_q < R_TWO) begin
            // bypass ratios have no phase to sample
            state_d  = S_GATE;
            clk_en_d = 1'b0;
          end else begin
            state_d = S_WAIT_LOW;
          end
        end
      end
      S_WAIT_LOW: begin
        clk_en_d = i_en;
        wcnt_d   = wcnt_q + W_STEP;
        if (fall || !i_en) begin
          state_d  = S_GATE;
          clk_en_d = 1'b0;
        end else if (wcnt_q == W_LAST) begin
          state_d   = S_GATE;
          clk_en_d  = 1'b0;
          timeout_d = 1'b1;
        end
      end
      S_GATE: begin
        clk_en_d = 1'b0;
        if (scnt_q == S_LAST) begin
          state_d = S_LOAD;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + S_STEP;
        end
      end
      S_LOAD: begin
        clk_en_d = 1'b0;
        ratio_d  = pend_q;
        state_d  = S_RESUME;
      end
      S_RESUME: begin
        clk_en_d = i_en;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        clk_en_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pend_q    <= R_INIT;
      ratio_q   <= R_INIT;
      wcnt_q    <= '0;
      scnt_q    <= '0;
      clk_en_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ratio_q   <= ratio_d;
      wcnt_q    <= wcnt_d;
      scnt_q    <= scnt_d;
      clk_en_q  <= clk_en_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      div_q     <= div_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_busy      = ~ready_q;
  assign o_clk_en    = clk_en_q;
  assign o_div_ratio = ratio_q;
  assign o_done      = done_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Directed bench for clk_div_ratio_ctrl with a simple
// ref-domain divider model providing the divided-clock feedback.
module tb_clk_div_ratio_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       req_valid;
  logic [7:0] req_ratio;
  logic       req_ready;
  logic       div_clk;
  logic       clk_en;
  logic [7:0] div_ratio;
  logic       busy;
  logic       done;
  logic       timeout;

  always #5 clk = ~clk;

  clk_div_ratio_ctrl dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_req_valid (req_valid),
    .i_req_ratio (req_ratio),
    .o_req_ready (req_ready),
    .i_div_clk   (div_clk),
    .o_clk_en    (clk_en),
    .o_div_ratio (div_ratio),
    .o_busy      (busy),
    .o_done      (done),
    .o_timeout   (timeout)
  );

  // divider model: counts while enabled, high for the first half
  logic [7:0] mcnt;
  logic [8:0] half;
  logic       stuck;

  assign half = ({1'b0, div_ratio} + 9'd1) >> 1;
  assign div_clk = stuck | ({1'b0, mcnt} < half);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mcnt <= 8'd0;
    else if (clk_en)
      mcnt <= (mcnt >= div_ratio - 8'd1) ? 8'd0 : mcnt + 8'd1;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fall = -1;
  int last_rat = -1;
  int last_done = -1;
  int t0, t1, tf;
  logic en_prev = 1'b0;
  logic [7:0] rat_prev = 8'd8;
  logic dc_cur = 1'b0;
  logic dc_p1 = 1'b0;
  logic phase_chk = 1'b0;
  logic saw_done;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    if (en_prev && !clk_en) begin
      last_fall = cyc;
      if (phase_chk)
        chk("fall_phase", {30'd0, dc_p1, dc_cur}, 32'd2);
    end
    if (div_ratio != rat_prev) begin
      last_rat = cyc;
      chk("ratio_chg_en", {30'd0, en_prev, clk_en}, 32'd0);
    end
    if (done) last_done = cyc;
    dc_p1 = dc_cur;
    dc_cur = div_clk;
    en_prev = clk_en;
    rat_prev = div_ratio;
  endtask

  task automatic request(input logic [7:0] r);
    req_valid = 1'b1;
    req_ratio = r;
    tick();
    t0 = cyc;
    req_valid = 1'b0;
    chk("ready_low_acc", 32'(req_ready), 32'd0);
    chk("busy_acc", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (done) break;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    req_valid = 1'b0;
    req_ratio = 8'd0;
    stuck = 1'b0;

    // 1: reset state, then enable follows i_en one cycle later
    repeat (3) tick();
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_ratio", 32'(div_ratio), 32'd8);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_clk_en0", 32'(clk_en), 32'd0);
    tick();
    chk("rel_clk_en1", 32'(clk_en), 32'd1);

    // 2: /8 -> 5 through the low-phase wait
    repeat (11) tick();
    phase_chk = 1'b1;
    request(8'd5);
    wait_done(100);
    phase_chk = 1'b0;
    chk("t2_ratio", 32'(div_ratio), 32'd5);
    chk("t2_w_nonzero", 32'(last_fall > t0), 32'd1);
    chk("t2_low_cycles", last_done - last_fall, 32'd4);
    chk("t2_ratio_lat", last_rat - last_fall, 32'd3);
    chk("t2_done_en", 32'(clk_en), 32'd1);
    tick();
    chk("t2_done_pulse", 32'(done), 32'd0);

    // 3: 0 is treated as 1, then bypass skips the wait
    repeat (4) tick();
    request(8'd0);
    wait_done(100);
    chk("t3_ratio1", 32'(div_ratio), 32'd1);
    repeat (3) tick();
    request(8'd4);
    chk("t3_gate_now", 32'(clk_en), 32'd0);
    wait_done(20);
    chk("t3_done_lat", last_done - t0, 32'd4);
    chk("t3_ratio_lat", last_rat - t0, 32'd3);
    chk("t3_ratio4", 32'(div_ratio), 32'd4);

    // 4: divided clock stuck high -> timeout path
    stuck = 1'b1;
    repeat (3) tick();
    request(8'd7);
    wait_done(1100);
    chk("t4_wait_len", last_fall - t0, 32'd1024);
    chk("t4_done_lat", last_done - t0, 32'd1028);
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_ratio7", 32'(div_ratio), 32'd7);
    stuck = 1'b0;
    repeat (2) tick();
    request(8'd7);
    chk("t4_to_clr", 32'(timeout), 32'd0);
    chk("t4_same_en", 32'(clk_en), 32'd1);
    wait_done(5);
    chk("t4_same_lat", last_done - t0, 32'd1);

    // 5: change to 8 with valid held; second (same) request waits
    repeat (5) tick();
    req_valid = 1'b1;
    req_ratio = 8'd8;
    tick();
    t0 = cyc;
    chk("t5_acc1", 32'(req_ready), 32'd0);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) break;
      chk("t5_ready_busy", 32'(req_ready), 32'd0);
    end
    chk("t5_done1", 32'(done), 32'd1);
    chk("t5_ratio8", 32'(div_ratio), 32'd8);
    chk("t5_ready_at_done", 32'(req_ready), 32'd1);
    tick();
    t1 = cyc;
    req_valid = 1'b0;
    chk("t5_acc2", 32'(req_ready), 32'd0);
    chk("t5_en_acc2", 32'(clk_en), 32'd1);
    tick();
    chk("t5_done2", 32'(done), 32'd1);
    chk("t5_done2_lat", last_done - t1, 32'd1);
    chk("t5_en_kept", 32'(last_fall < t1), 32'd1);
    chk("t5_ratio_same", 32'(div_ratio), 32'd8);

    // 6a: reset mid-GATE drops the pending ratio
    repeat (3) tick();
    request(8'd3);
    for (int i = 0; i < 30; i++) begin
      if (!clk_en) break;
      tick();
    end
    chk("t6_gated", 32'(clk_en), 32'd0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_en", 32'(clk_en), 32'd0);
    chk("t6_rst_ratio", 32'(div_ratio), 32'd8);
    chk("t6_rst_ready", 32'(req_ready), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_rel_en", 32'(clk_en), 32'd1);
    saw_done = 1'b0;
    repeat (8) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("t6_no_done", 32'(saw_done), 32'd0);
    chk("t6_ratio_kept", 32'(div_ratio), 32'd8);

    // 6b: i_en dropped in WAIT_LOW
    stuck = 1'b1;
    repeat (2) tick();
    request(8'd5);
    repeat (3) tick();
    chk("t6b_wait_en", 32'(clk_en), 32'd1);
    en = 1'b0;
    tick();
    tf = cyc;
    chk("t6b_gate_en", 32'(clk_en), 32'd0);
    chk("t6b_fall_now", last_fall, tf);
    wait_done(10);
    chk("t6b_done_lat", last_done - tf, 32'd4);
    chk("t6b_done_en", 32'(clk_en), 32'd0);
    chk("t6b_ratio5", 32'(div_ratio), 32'd5);
    chk("t6b_no_to", 32'(timeout), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
